// File: rtl/cpu_pkg.sv
// Shared CPU package: default data/register-file sizes and the writeback
// requester identifiers used by the register file and its writeback arbiter.
package cpu_pkg;

  localparam int CPU_DATA_WIDTH    = 32;
  localparam int CPU_NUM_REGISTERS = 32;

  // Writeback requesters; also the encoding of the arbiter's last-grant flop.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage : cpu_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter between the ALU and MEM
// writeback requesters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_valid_i       ALU requester valid
//   mem_valid_i       MEM requester valid
//   alu_gnt_o         ALU granted this cycle (implies alu_valid_i)
//   mem_gnt_o         MEM granted this cycle (implies mem_valid_i)
//   last_grant_o      requester granted most recently (debug view of state)
//
// Handshake: a requester is granted when its valid is high and it wins the
// arbitration; the grant is combinational from valid and last-grant state.
// A lone valid requester always wins; on a tie the requester that was not
// granted last wins. Last-grant resets to ALU so MEM wins the first tie.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_valid_i,
  input  logic    mem_valid_i,
  output logic    alu_gnt_o,
  output logic    mem_gnt_o,
  output req_id_e last_grant_o
);

  req_id_e last_grant_q;
  req_id_e last_grant_d;

  always_comb begin
    alu_gnt_o    = 1'b0;
    mem_gnt_o    = 1'b0;
    last_grant_d = last_grant_q;
    // No grants while reset is held, so nothing can be captured downstream.
    if (rst_n) begin
      if (alu_valid_i && mem_valid_i) begin
        if (last_grant_q == REQ_ALU) mem_gnt_o = 1'b1;
        else                         alu_gnt_o = 1'b1;
      end else begin
        alu_gnt_o = alu_valid_i;
        mem_gnt_o = mem_valid_i;
      end
    end
    // Last-grant only moves on an actual grant.
    if (alu_gnt_o) last_grant_d = REQ_ALU;
    if (mem_gnt_o) last_grant_d = REQ_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= REQ_ALU;
    else        last_grant_q <= last_grant_d;
  end

  assign last_grant_o = last_grant_q;

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file writeback arbiter with a pending-write
// scoreboard.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   issue_valid/issue_reg         decode reserves a destination register
//   issue_ready                   reservation accepted (register not pending)
//   flush                         clear all reservations
//   query_reg_1/2, query_busy_1/2 source-operand pending checks
//   alu_*/mem_*                   writeback requests (valid/reg/data/ready)
//   write_register/write_data     register-file write port (reg 0 = no-op)
//   wb_error                      sticky: write committed to a non-pending reg
//
// Handshake: a writeback requester holds valid/reg/data stable until it sees
// ready high in the same cycle; ready is valid && granted. The granted write
// is registered and commits to the register file one cycle after the grant.
// The pending bit of a register clears on the edge where that commit happens,
// so busy drops exactly when the new value becomes readable.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = CPU_DATA_WIDTH,
  parameter int NUM_REGISTERS = CPU_NUM_REGISTERS,
  parameter int REG_IDX_W     = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_IDX_W-1:0]  issue_reg,
  output logic                  issue_ready,
  input  logic                  flush,
  input  logic [REG_IDX_W-1:0]  query_reg_1,
  input  logic [REG_IDX_W-1:0]  query_reg_2,
  output logic                  query_busy_1,
  output logic                  query_busy_2,
  input  logic                  alu_valid,
  input  logic [REG_IDX_W-1:0]  alu_reg,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_IDX_W-1:0]  mem_reg,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic [REG_IDX_W-1:0]  write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  wb_error
);

  logic [NUM_REGISTERS-1:0] pending_q, pending_d;
  logic [REG_IDX_W-1:0]     write_register_q, write_register_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     wb_error_q, wb_error_d;

  logic    alu_gnt, mem_gnt;
  req_id_e last_grant;
  logic    issue_fire;
  logic    commit_fire;

  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst_n        (rst),
    .alu_valid_i  (alu_valid),
    .mem_valid_i  (mem_valid),
    .alu_gnt_o    (alu_gnt),
    .mem_gnt_o    (mem_gnt),
    .last_grant_o (last_grant)
  );

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Pending bits are read straight from the flops: same-cycle commits are
  // not bypassed into the busy outputs.
  assign issue_ready  = !pending_q[issue_reg];
  assign query_busy_1 = pending_q[query_reg_1];
  assign query_busy_2 = pending_q[query_reg_2];

  assign issue_fire  = issue_valid && issue_ready && (issue_reg != '0);
  assign commit_fire = (write_register_q != '0);

  always_comb begin
    pending_d = pending_q;
    // Clear is applied after set so a commit wins over a same-edge issue.
    if (issue_fire)  pending_d[issue_reg]        = 1'b1;
    if (commit_fire) pending_d[write_register_q] = 1'b0;
    if (flush)       pending_d                   = '0;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    write_register_d = '0;
    write_data_d     = write_data_q;
    if (mem_gnt) begin
      write_register_d = mem_reg;
      write_data_d     = mem_data;
    end else if (alu_gnt) begin
      write_register_d = alu_reg;
      write_data_d     = alu_data;
    end
  end

  // A commit on the flush edge is legitimate in-flight work, so it is not
  // checked against the pending bits.
  always_comb begin
    wb_error_d = wb_error_q;
    if (commit_fire && !pending_q[write_register_q] && !flush) wb_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q        <= '0;
      write_register_q <= '0;
      write_data_q     <= '0;
      wb_error_q       <= 1'b0;
    end else begin
      pending_q        <= pending_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      wb_error_q       <= wb_error_d;
    end
  end

  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign wb_error       = wb_error_q;

  // Debug view of the arbiter state, only used for simulation assertions.
  logic last_grant_dbg;
  assign last_grant_dbg = (last_grant == REQ_MEM);
  logic unused_dbg;
  assign unused_dbg = last_grant_dbg;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int RW = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          issue_valid = 1'b0;
  logic [RW-1:0] issue_reg   = '0;
  logic          issue_ready;
  logic          flush       = 1'b0;
  logic [RW-1:0] query_reg_1 = '0;
  logic [RW-1:0] query_reg_2 = '0;
  logic          query_busy_1, query_busy_2;
  logic          alu_valid   = 1'b0;
  logic [RW-1:0] alu_reg     = '0;
  logic [DW-1:0] alu_data    = '0;
  logic          alu_ready;
  logic          mem_valid   = 1'b0;
  logic [RW-1:0] mem_reg     = '0;
  logic [DW-1:0] mem_data    = '0;
  logic          mem_ready;
  logic [RW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic          wb_error;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_reg      (issue_reg),
    .issue_ready    (issue_ready),
    .flush          (flush),
    .query_reg_1    (query_reg_1),
    .query_reg_2    (query_reg_2),
    .query_busy_1   (query_busy_1),
    .query_busy_2   (query_busy_2),
    .alu_valid      (alu_valid),
    .alu_reg        (alu_reg),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_reg        (mem_reg),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .write_register (write_register),
    .write_data     (write_data),
    .wb_error       (wb_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #2;
    chk("rst_wr_reg",     write_register, 0);
    chk("rst_wr_data",    write_data, 0);
    chk("rst_wb_error",   wb_error, 0);
    chk("rst_alu_ready",  alu_ready, 0);
    chk("rst_mem_ready",  mem_ready, 0);
    chk("rst_issue_rdy",  issue_ready, 1);
    chk("rst_busy1",      query_busy_1, 0);
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("rst_no_commit",  write_register, 0);
    rst = 1'b1;

    // ---------------- issue r5, alu writes r5 ----------------
    issue_valid = 1'b1; issue_reg = 5;
    #1 chk("r5_issue_rdy", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    query_reg_1 = 5;
    #1 chk("r5_busy_set", query_busy_1, 1);
    alu_valid = 1'b1; alu_reg = 5; alu_data = 32'hDEAD;
    #1;
    chk("r5_alu_ready", alu_ready, 1);
    chk("r5_mem_ready", mem_ready, 0);
    tick();                          // grant edge N
    alu_valid = 1'b0;
    chk("r5_wr_reg",   write_register, 5);
    chk("r5_wr_data",  write_data, 32'hDEAD);
    chk("r5_busy_n1",  query_busy_1, 1);
    tick();                          // commit edge
    chk("r5_busy_n2",  query_busy_1, 0);
    chk("r5_wr_idle",  write_register, 0);
    chk("r5_wb_error", wb_error, 0);

    // ---------------- round robin after reset ----------------
    rst_pulse();
    alu_valid = 1'b1; alu_reg = 0; alu_data = 32'h1111;
    mem_valid = 1'b1; mem_reg = 0; mem_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_mem_ready_%0d", i), mem_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_alu_ready_%0d", i), alu_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      chk($sformatf("rr_wr_data_%0d", i), write_data, (i % 2 == 0) ? 32'h2222 : 32'h1111);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("rr_wb_error", wb_error, 0);

    // ---------------- r7 re-issue blocked until commit ----------------
    issue_valid = 1'b1; issue_reg = 7;
    tick();
    query_reg_2 = 7;
    #1;
    chk("r7_reissue_rdy0", issue_ready, 0);
    chk("r7_busy",         query_busy_2, 1);
    tick();
    chk("r7_still_blk",    issue_ready, 0);
    mem_valid = 1'b1; mem_reg = 7; mem_data = 32'h77;
    #1 chk("r7_mem_ready", mem_ready, 1);
    tick();                          // grant edge
    mem_valid = 1'b0;
    chk("r7_wr_reg",       write_register, 7);
    chk("r7_blk_grant",    issue_ready, 0);
    tick();                          // commit edge
    chk("r7_rdy_after",    issue_ready, 1);
    chk("r7_busy_clr",     query_busy_2, 0);
    tick();                          // issue accepted
    issue_valid = 1'b0;
    chk("r7_busy_again",   query_busy_2, 1);
    chk("r7_wb_error",     wb_error, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("r7_flush_clr",    query_busy_2, 0);

    // ---------------- mem writes r0 then unreserved r9 ----------------
    mem_valid = 1'b1; mem_reg = 0; mem_data = 32'h1234;
    #1 chk("r0_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    chk("r0_wr_reg",   write_register, 0);
    chk("r0_wr_data",  write_data, 32'h1234);
    tick();
    chk("r0_no_error", wb_error, 0);
    mem_valid = 1'b1; mem_reg = 9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    chk("r9_wr_reg",   write_register, 9);
    chk("r9_err_pre",  wb_error, 0);
    tick();
    chk("r9_err_set",  wb_error, 1);
    tick();
    chk("r9_err_hold", wb_error, 1);

    // ---------------- flush with alu r3 commit in flight ----------------
    rst_pulse();
    #1 chk("fl_err_rst", wb_error, 0);
    issue_valid = 1'b1; issue_reg = 3;
    tick();
    issue_reg = 4;
    tick();
    issue_valid = 1'b0;
    query_reg_1 = 3; query_reg_2 = 4;
    #1;
    chk("fl_busy3", query_busy_1, 1);
    chk("fl_busy4", query_busy_2, 1);
    alu_valid = 1'b1; alu_reg = 3; alu_data = 32'h33;
    tick();                          // grant edge
    alu_valid = 1'b0;
    chk("fl_wr_reg", write_register, 3);
    flush = 1'b1;
    tick();                          // flush + commit edge
    flush = 1'b0;
    chk("fl_busy3_clr", query_busy_1, 0);
    chk("fl_busy4_clr", query_busy_2, 0);
    chk("fl_wb_error",  wb_error, 0);
    tick();
    chk("fl_wb_error2", wb_error, 0);

    // ---------------- reset mid-grant ----------------
    issue_valid = 1'b1; issue_reg = 6;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 6; alu_data = 32'h66;
    query_reg_1 = 6;
    tick();                          // grant edge, alu stays valid
    chk("mr_wr_reg",   write_register, 6);
    chk("mr_busy",     query_busy_1, 1);
    rst = 1'b0;
    #1;
    chk("mr_wr_reg0",  write_register, 0);
    chk("mr_wr_data0", write_data, 0);
    chk("mr_busy0",    query_busy_1, 0);
    chk("mr_alu_rdy0", alu_ready, 0);
    issue_reg = 6;
    #1 chk("mr_issue_rdy", issue_ready, 1);
    tick();
    chk("mr_in_rst_wr", write_register, 0);
    rst = 1'b1;
    alu_valid = 1'b0;
    tick();
    chk("mr_post_wr",   write_register, 0);
    chk("mr_post_err",  wb_error, 0);
    chk("mr_post_busy", query_busy_1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, register data width; NUM_REGISTERS, 32, register count; REG_IDX_W, $clog2(NUM_REGISTERS), local index width.
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode reserves destination register.
- issue_reg  in  REG_IDX_W  destination to reserve.
- issue_ready  out  1  reservation accepted this cycle.
- flush  in  1  clear all reservations.
- query_reg_1, query_reg_2  in  REG_IDX_W  source registers to check.
- query_busy_1, query_busy_2  out  1  source has a pending write.
- alu_valid, mem_valid  in  1  writeback request.
- alu_reg, mem_reg  in  REG_IDX_W  writeback destination.
- alu_data, mem_data  in  DATA_WIDTH  writeback value.
- alu_ready, mem_ready  out  1  request granted this cycle.
- write_register  out  REG_IDX_W  register-file write index; 0 = no-op.
- write_data  out  DATA_WIDTH  register-file write data.
- wb_error  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL keep a pending bit per register; bit 0 is hardwired 0.
REQ-004 SHALL drive issue_ready = !pending[issue_reg] (combinational); index 0 always ready.
REQ-005 SHALL set pending[issue_reg] at the clock edge where issue_valid && issue_ready && issue_reg != 0.
REQ-006 SHALL drive query_busy_n = pending[query_reg_n] combinationally; no bypass of same-cycle commits.
REQ-007 SHALL grant at most one requester per cycle; ready = valid && granted, combinational from valid and arbiter state.
REQ-008 SHALL arbitrate round-robin: a lone valid requester is granted; with both valid, the requester not granted last wins; after reset, mem wins the first tie.
REQ-009 SHALL update last-grant only on an actual grant.
REQ-010 SHALL register the granted reg/data into write_register/write_data at the grant edge, so the register file commits one cycle after the grant (latency 1); with no grant, write_register = 0 next cycle.
REQ-011 SHALL clear pending[r] at the edge where the register file commits r (write_register == r, r != 0), so busy drops exactly when the new value is readable.
REQ-012 SHALL give clear priority over set when both target the same register at the same edge; REQ-004 prevents that case in legal use.
REQ-013 SHALL set wb_error when a nonzero write commits to a register whose pending bit is 0; it holds until reset.
REQ-014 SHALL treat a writeback to register 0 as a normal grant, passed to the register file as a no-op, with no pending or error effect.
REQ-015 SHALL on flush clear all pending bits at that edge, overriding same-edge sets; in-flight write_register still commits and does not raise wb_error on that edge.
REQ-016 SHALL hold valid/reg/data stability as the requester's duty; the arbiter does not buffer ungranted requests.

Reset
REQ-017 SHALL, while rst is low, asynchronously force: pending = 0, last-grant = alu, write_register = 0, write_data = 0, wb_error = 0.
REQ-018 SHALL hold alu_ready = mem_ready = 0 during reset; issue_ready follows pending, so it reads 1.
REQ-019 SHALL drop a grant given in the cycle reset asserts; no register-file write follows.

Structure
REQ-020 SHALL put DATA_WIDTH/NUM_REGISTERS defaults and a requester-id enum (REQ_ALU, REQ_MEM) in a shared cpu package used by the register file and this block.
REQ-021 SHALL have one sub-module, rr_arbiter2 (2-way round-robin, valid in / grant out, last-grant flop); the scoreboard stays inline.

Verification
REQ-022 SHALL cover: issue r5; next cycle query r5 -> busy=1; alu writes r5=0xDEAD at grant cycle N -> write_register=5, write_data=0xDEAD at N+1; busy=0 at N+2; wb_error=0.
REQ-023 SHALL cover: alu and mem valid on 4 consecutive cycles after reset -> grants mem, alu, mem, alu; the ungranted ready is 0 each cycle.
REQ-024 SHALL cover: r7 pending, issue r7 again -> issue_ready=0 until commit of r7, then issue accepted the next cycle.
REQ-025 SHALL cover: mem writes r9 with r9 not pending -> wb_error=1 one cycle after commit and stays 1; mem writes r0 -> write_register=0, no error.
REQ-026 SHALL cover: r3, r4 pending, flush with alu r3 commit in flight -> all busy=0 next cycle, wb_error=0.
REQ-027 SHALL cover: rst low mid-grant -> write_register=0, all pending=0 immediately, no commit after release.
